// File: rtl/mem_wb_stage.sv
// mem_wb_stage: resolves ALU results, branches and overflow traps, runs lw/sw over req/ack, drives register writeback
module mem_wb_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] alu_c,
  input  logic [2:0]  alu_flags,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc_plus4,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        ovf_trap,
  output logic [31:0] trap_pc,
  output logic        bus_err,
  output logic        illegal
);
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_rt;
  logic [31:0]   r_pc4;
  logic [5:0]    w_op, w_fn;
  logic [4:0]    w_dst;
  logic          w_rtype, w_r_alu, w_r_slt, w_i_alu, w_i_slt, w_beq, w_bne, w_lw, w_sw;
  logic          w_wr, w_slt, w_ovf, w_legal, w_unused;
  logic [31:0]   w_tgt;
  assign w_op     = instr[31:26];
  assign w_fn     = instr[5:0];
  assign w_rtype  = w_op == 6'h00;
  assign w_r_alu  = w_rtype & (w_fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27]});
  assign w_r_slt  = w_rtype & (w_fn inside {6'h2A, 6'h2B});
  assign w_i_alu  = w_op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
  assign w_i_slt  = w_op inside {6'h0A, 6'h0B};
  assign w_beq    = w_op == 6'h04;
  assign w_bne    = w_op == 6'h05;
  assign w_lw     = w_op == 6'h23;
  assign w_sw     = w_op == 6'h2B;
  assign w_slt    = w_r_slt | w_i_slt;
  assign w_wr     = w_r_alu | w_i_alu | w_slt;
  // only signed add/sub/addi trap; the unsigned forms ignore the overflow flag
  assign w_ovf    = alu_flags[0] & ((w_rtype & (w_fn inside {6'h20, 6'h22})) | (w_op == 6'h08));
  assign w_legal  = w_wr | w_beq | w_bne;
  assign w_dst    = w_rtype ? instr[15:11] : instr[20:16];
  assign w_tgt    = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign w_unused = ^{instr[25:21], instr[10:6], alu_c[1:0]};
  assign in_ready = r_state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rt      <= '0;
      r_pc4     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      ovf_trap  <= 1'b0;
      trap_pc   <= '0;
      bus_err   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      wb_en    <= 1'b0;
      br_taken <= 1'b0;
      ovf_trap <= 1'b0;
      bus_err  <= 1'b0;
      illegal  <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_pc4 <= pc_plus4;
          r_rt  <= instr[20:16];
          r_cnt <= '0;
          if (w_lw | w_sw) begin
            r_state   <= MEM;
            mem_req   <= 1'b1;
            mem_we    <= w_sw;
            mem_addr  <= {alu_c[31:2], 2'b00};
            mem_wdata <= rt_data;
          end else begin
            r_state   <= RESP;
            wb_en     <= w_wr & ~w_ovf & (|w_dst);
            wb_addr   <= w_dst;
            wb_data   <= w_slt ? {31'b0, alu_flags[1]} : alu_c;
            br_taken  <= (w_beq & alu_flags[2]) | (w_bne & ~alu_flags[2]);
            br_target <= w_tgt;
            ovf_trap  <= w_ovf;
            trap_pc   <= pc_plus4 - 32'd4;
            illegal   <= ~w_legal;
          end
        end
        MEM: if (mem_ack) begin
          r_state <= RESP;
          mem_req <= 1'b0;
          wb_en   <= ~mem_we & (|r_rt);
          wb_addr <= r_rt;
          wb_data <= mem_rdata;
        end else if (r_cnt == CW'(MEM_TIMEOUT - 1)) begin
          r_state <= RESP;
          mem_req <= 1'b0;
          bus_err <= 1'b1;
          trap_pc <= r_pc4 - 32'd4;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
